// File: rtl/axis_frame_trailer_append.sv
// Purpose : appends one trailer word {0, MAGIC, frame_seq, beat_count} to each AXI4-Stream frame.
// Latency : 1 cycle from input handshake to m_axis_tvalid; a frame of N beats uses N+1 output cycles.
// Backpressure: s_axis_tready follows the single output slot; it is held low during the trailer cycle.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   enable                - trailer insertion enable, sampled on the first beat of each frame
//   s_axis_*              - upstream stream (tvalid/tdata/tlast in, tready out)
//   m_axis_*              - downstream stream (tvalid/tdata/tlast out, tready in)
//   frame_done            - one-cycle pulse after the final output beat of a frame is accepted
//   frame_seq             - sequence number the next trailer will carry
module axis_frame_trailer_append #(
   parameter int          DATA_WIDTH = 64,
   parameter logic [15:0] MAGIC      = 16'hA5C3,
   parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  frame_done,
   output logic [15:0]           frame_seq
);

   typedef enum logic {ST_PASS, ST_TRAILER} state_t;

   state_t                state, state_nxt;
   logic [15:0]           beat_cnt;
   logic [15:0]           beat_cnt_sat;
   logic                  frame_en;
   logic                  first_beat;
   logic                  slot_free;
   logic                  in_hs;
   logic                  beat_en;
   logic                  pass_last;
   logic [DATA_WIDTH-1:0] trailer_dat;

   assign slot_free = !m_axis_tvalid || m_axis_tready;
   assign in_hs     = s_axis_tvalid && s_axis_tready;

   // On the first beat the live enable applies; afterwards the latched copy does,
   // so toggling enable mid-frame cannot split a frame's treatment.
   assign beat_en   = first_beat ? enable : frame_en;

   // Last beat of a frame that is not getting a trailer carries tlast itself.
   assign pass_last = s_axis_tlast && !beat_en;

   assign beat_cnt_sat = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;

   always_comb begin
      trailer_dat        = '0;
      trailer_dat[47:0]  = {MAGIC, frame_seq, beat_cnt};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_PASS;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      case (state)
         ST_PASS: begin
            s_axis_tready = slot_free;
            if (s_axis_tvalid && slot_free && s_axis_tlast && beat_en) begin
               state_nxt = ST_TRAILER;
            end
         end
         ST_TRAILER: begin
            if (slot_free) begin
               state_nxt = ST_PASS;
            end
         end
         default: state_nxt = ST_PASS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         frame_done    <= 1'b0;
         frame_seq     <= SEQ_INIT;
         beat_cnt      <= 16'd0;
         frame_en      <= 1'b0;
         first_beat    <= 1'b1;
      end else begin
         frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
         if (state == ST_PASS) begin
            if (in_hs) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= s_axis_tdata;
               m_axis_tlast  <= pass_last;
               first_beat    <= pass_last;
               beat_cnt      <= pass_last ? 16'd0 : beat_cnt_sat;
               if (first_beat) begin
                  frame_en <= enable;
               end
            end else if (m_axis_tready) begin
               m_axis_tvalid <= 1'b0;
            end
         end else if (slot_free) begin
            // beat_cnt already includes the frame's last data beat here.
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= trailer_dat;
            m_axis_tlast  <= 1'b1;
            frame_seq     <= frame_seq + 16'd1;
            beat_cnt      <= 16'd0;
            first_beat    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_trailer_append.sv
// Purpose : self-checking bench for axis_frame_trailer_append against a frame-level reference model.
// Latency : drives inputs 1 time unit after the rising edge, samples outputs on the falling edge.
// Backpressure: m_axis_tready is driven always-1, always-0 or random depending on rdy_mode.
module tb_axis_frame_trailer_append;

   localparam int          DW       = 64;
   localparam logic [15:0] MAGIC    = 16'hA5C3;
   localparam logic [15:0] SEQ_INIT = 16'hFFFE;   // wraps after two trailers

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic          m_axis_tvalid;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b1;
   logic          frame_done;
   logic [15:0]   frame_seq;

   axis_frame_trailer_append #(.DATA_WIDTH(DW), .MAGIC(MAGIC), .SEQ_INIT(SEQ_INIT)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .frame_done(frame_done), .frame_seq(frame_seq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [DW:0] exp_q[$];     // {tlast, tdata}
   logic [DW:0] got_q[$];
   logic [15:0] m_seq = SEQ_INIT;
   int          exp_frames = 0;
   int          done_cnt   = 0;
   int          srdy_low   = 0;
   int          stall_err  = 0;
   int          timeouts   = 0;
   int          rdy_mode   = 0;   // 0: ready high, 1: random, 2: ready low

   task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Downstream ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Output monitor: collects accepted beats, counts pulses, watches stall stability.
   logic        prev_stall = 1'b0;
   logic [DW:0] prev_beat  = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !(m_axis_tvalid && {m_axis_tlast, m_axis_tdata} == prev_beat))
            stall_err++;
         if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
         if (frame_done) done_cnt++;
         if (!s_axis_tready) srdy_low++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
   end

   // Sends one frame and records what the stage should produce for it.
   task automatic send_frame(input int n, input bit en);
      bit          acc;
      int          g;
      logic [15:0] cnt;
      for (int i = 0; i < n; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = {$urandom, $urandom};
         s_axis_tlast  = (i == n - 1);
         enable        = (i == 0) ? en : 1'($urandom_range(0, 1));
         exp_q.push_back({(i == n - 1) && !en, s_axis_tdata});
         g = 0;
         do begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            g++;
         end while (!acc && g < 1000);
         if (!acc) timeouts++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (en) begin
         cnt = (n > 65535) ? 16'hFFFF : 16'(n);
         exp_q.push_back({1'b1, 16'h0000, MAGIC, m_seq, cnt});
         m_seq = m_seq + 16'd1;
      end
      exp_frames++;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (got_q.size() < exp_q.size() && g < 5000) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic compare_out(input string tag);
      int mism = 0;
      int n;
      check({tag, "_len"}, DW'(got_q.size()), DW'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
      check({tag, "_beats"}, DW'(mism), '0);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int d0, l0;
      logic [DW:0] last_beat;

      // Reset state
      #12;
      check("rst_tvalid", m_axis_tvalid, '0);
      check("rst_tdata",  m_axis_tdata,  '0);
      check("rst_tlast",  m_axis_tlast,  '0);
      check("rst_done",   frame_done,    '0);
      check("rst_seq",    frame_seq,     SEQ_INIT);
      check("rst_sready", s_axis_tready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: 3-beat frame with trailer
      d0 = done_cnt;
      send_frame(3, 1'b1);
      wait_drain();
      last_beat = got_q.size() > 0 ? got_q[$] : '0;
      check("t1_trailer", last_beat, {1'b1, 16'h0, MAGIC, SEQ_INIT, 16'd3});
      compare_out("t1");
      check("t1_done", DW'(done_cnt - d0), 1);
      check("t1_seq", frame_seq, m_seq);

      // 2: two back-to-back single-beat frames; sequence wraps
      d0 = done_cnt;
      l0 = srdy_low;
      send_frame(1, 1'b1);
      send_frame(1, 1'b1);
      wait_drain();
      compare_out("t2");
      check("t2_sready_low", DW'(srdy_low - l0), 2);
      check("t2_done", DW'(done_cnt - d0), 2);
      check("t2_seq", frame_seq, m_seq);

      // 3: trailer disabled, pass-through
      d0 = done_cnt;
      send_frame(4, 1'b0);
      wait_drain();
      compare_out("t3");
      check("t3_done", DW'(done_cnt - d0), 1);
      check("t3_seq", frame_seq, m_seq);

      // 4: random downstream backpressure, several frames
      rdy_mode = 1;
      d0 = done_cnt;
      send_frame(10, 1'b1);
      send_frame(3, 1'b0);
      send_frame(7, 1'b1);
      rdy_mode = 0;
      wait_drain();
      compare_out("t4");
      check("t4_done", DW'(done_cnt - d0), 3);
      check("t4_seq", frame_seq, m_seq);
      check("stall_stable", DW'(stall_err), 0);

      // 5: long frame saturates the count field
      send_frame(70000, 1'b1);
      wait_drain();
      last_beat = got_q.size() > 0 ? got_q[$] : '0;
      check("t5_trailer", last_beat[15:0], 16'hFFFF);
      compare_out("t5");
      check("t5_seq", frame_seq, m_seq);

      // 6: reset while a trailer is pending under backpressure
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send_frame(1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_tvalid", m_axis_tvalid, '0);
      check("t6_seq", frame_seq, SEQ_INIT);
      exp_q.delete();
      got_q.delete();
      m_seq = SEQ_INIT;
      rdy_mode = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(5, 1'b1);
      wait_drain();
      last_beat = got_q.size() > 0 ? got_q[$] : '0;
      check("t6_trailer", last_beat, {1'b1, 16'h0, MAGIC, SEQ_INIT, 16'd5});
      compare_out("t6");
      check("t6_seq_after", frame_seq, m_seq);

      check("timeouts", DW'(timeouts), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
